pll_lock_reset_seq: RTL



---
 rtl/pll_lock_reset_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_reset_seq.sv
// Staged reset sequencer for the CCC clock domain: qualifies PLL lock, releases
// peripheral, fabric and system-ready in order, and re-asserts all on lock loss.
module pll_lock_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int LOSS_FILTER        = 4,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 PLL_LOCK,
    input  logic                 SOFT_RESET_REQ,
    output logic                 PERIPH_RESET_N,
    output logic                 FABRIC_RESET_N,
    output logic                 SYS_READY,
    output logic [CNT_WIDTH-1:0] LOCK_LOSS_CNT,
    output logic [2:0]           SEQ_STATE
);

    // One stage counter serves both the stabilization window and the release delays.
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int SW      = $clog2(CNT_MAX);
    localparam int FW      = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        REL_PERIPH = 3'd2,
        REL_FABRIC = 3'd3,
        RUN        = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         stage_cnt_q, stage_cnt_d;
    logic [FW-1:0]         filt_cnt_q, filt_cnt_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  periph_q, periph_d;
    logic                  fabric_q, fabric_d;
    logic                  ready_q, ready_d;
    logic [CNT_WIDTH-1:0]  loss_cnt_q, loss_cnt_d;
    logic                  lock_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign lock_s = sync2_q;

    always_comb begin
        sync1_d     = PLL_LOCK;
        sync2_d     = sync1_q;
        state_d     = state_q;
        stage_cnt_d = stage_cnt_q;
        filt_cnt_d  = filt_cnt_q;
        periph_d    = periph_q;
        fabric_d    = fabric_q;
        ready_d     = ready_q;
        loss_cnt_d  = loss_cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                periph_d    = 1'b0;
                fabric_d    = 1'b0;
                ready_d     = 1'b0;
                stage_cnt_d = '0;
                filt_cnt_d  = '0;
                if (lock_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                periph_d   = 1'b0;
                fabric_d   = 1'b0;
                ready_d    = 1'b0;
                filt_cnt_d = '0;
                if (!lock_s) begin
                    state_d     = WAIT_LOCK;
                    stage_cnt_d = '0;
                end else if (stage_cnt_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d     = REL_PERIPH;
                    stage_cnt_d = '0;
                    periph_d    = 1'b1;
                end else begin
                    stage_cnt_d = stage_cnt_q + SW'(1);
                end
            end
            REL_PERIPH, REL_FABRIC, RUN: begin
                if (state_q == REL_PERIPH) begin
                    if (stage_cnt_q == SW'(STAGE_DELAY - 1)) begin
                        state_d     = REL_FABRIC;
                        stage_cnt_d = '0;
                        fabric_d    = 1'b1;
                    end else begin
                        stage_cnt_d = stage_cnt_q + SW'(1);
                    end
                end else if (state_q == REL_FABRIC) begin
                    if (stage_cnt_q == SW'(STAGE_DELAY - 1)) begin
                        state_d     = RUN;
                        stage_cnt_d = '0;
                        ready_d     = 1'b1;
                    end else begin
                        stage_cnt_d = stage_cnt_q + SW'(1);
                    end
                end

                filt_cnt_d = lock_s ? '0 : filt_cnt_q + FW'(1);

                // Lock loss takes priority over a coincident soft reset request.
                if (!lock_s && (filt_cnt_q == FW'(LOSS_FILTER - 1))) begin
                    state_d     = WAIT_LOCK;
                    stage_cnt_d = '0;
                    filt_cnt_d  = '0;
                    periph_d    = 1'b0;
                    fabric_d    = 1'b0;
                    ready_d     = 1'b0;
                    loss_cnt_d  = sat_inc(loss_cnt_q);
                end else if (SOFT_RESET_REQ) begin
                    state_d     = STABILIZE;
                    stage_cnt_d = '0;
                    filt_cnt_d  = '0;
                    periph_d    = 1'b0;
                    fabric_d    = 1'b0;
                    ready_d     = 1'b0;
                end
            end
            default: begin
                state_d     = WAIT_LOCK;
                stage_cnt_d = '0;
                filt_cnt_d  = '0;
                periph_d    = 1'b0;
                fabric_d    = 1'b0;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= WAIT_LOCK;
            stage_cnt_q <= '0;
            filt_cnt_q  <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            periph_q    <= 1'b0;
            fabric_q    <= 1'b0;
            ready_q     <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stage_cnt_q <= stage_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            periph_q    <= periph_d;
            fabric_q    <= fabric_d;
            ready_q     <= ready_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign PERIPH_RESET_N = periph_q;
    assign FABRIC_RESET_N = fabric_q;
    assign SYS_READY      = ready_q;
    assign LOCK_LOSS_CNT  = loss_cnt_q;
    assign SEQ_STATE      = state_q;

endmodule
